// File: rtl/led_blink_encoder.sv
// Purpose : serialises a WIDTH-bit word onto one LED, MSB first; a 1 bit is a long
//           flash, a 0 bit a short flash, separated by gaps and closed by a frame gap.
// Latency : led lights on the cycle after the valid/ready handshake; done pulses in the
//           first idle cycle after the frame gap.
// Backpressure: ready is high only while idle; valid during a frame is ignored (no queue).
//
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - synchronous active-low reset
//   data   - WIDTH-bit value, sampled only at the handshake
//   valid  - frame offered
//   ready  - block idle and able to accept a frame
//   led    - registered LED drive, 1 = lit
//   busy   - frame in progress (~ready)
//   done   - one-cycle pulse at frame completion
module led_blink_encoder #(
    parameter int WIDTH            = 4,
    parameter int SHORT_CYCLES     = 2,
    parameter int LONG_CYCLES      = 6,
    parameter int GAP_CYCLES       = 3,
    parameter int FRAME_GAP_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             led,
    output logic             busy,
    output logic             done
);

    // Counter must hold the longest phase length without wrapping.
    localparam int MAX_A   = (LONG_CYCLES > SHORT_CYCLES) ? LONG_CYCLES : SHORT_CYCLES;
    localparam int MAX_B   = (FRAME_GAP_CYCLES > GAP_CYCLES) ? FRAME_GAP_CYCLES : GAP_CYCLES;
    localparam int MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);
    localparam int IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(SHORT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] FGAP_LD  = CNT_W'(FRAME_GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2,
        S_FGAP = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               r_led;
    logic               w_led_nxt;
    logic               r_done;
    logic               w_done_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_idx   <= '0;
            r_led   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_idx   <= w_idx_nxt;
            r_led   <= w_led_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                // ready is implied by being in IDLE, so valid alone is the handshake.
                if (valid) begin
                    w_state_nxt = S_ON;
                    w_shift_nxt = data;
                    w_idx_nxt   = IDX_W'(WIDTH - 1);
                    w_cnt_nxt   = data[WIDTH-1] ? LONG_LD : SHORT_LD;
                end
            end
            S_ON: begin
                if (r_cnt == '0) begin
                    if (r_idx == '0) begin
                        // Last bit goes straight to the frame gap, no inter-bit gap.
                        w_state_nxt = S_FGAP;
                        w_cnt_nxt   = FGAP_LD;
                    end else begin
                        // Shift now so the MSB holds the next bit during the gap.
                        w_state_nxt = S_GAP;
                        w_cnt_nxt   = GAP_LD;
                        w_shift_nxt = r_shift << 1;
                        w_idx_nxt   = r_idx - 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_ON;
                    w_cnt_nxt   = r_shift[WIDTH-1] ? LONG_LD : SHORT_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_FGAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // led is registered from the next state so it tracks ON with no extra delay.
        w_led_nxt = (w_state_nxt == S_ON);
    end

    assign ready = (r_state == S_IDLE);
    assign busy  = ~ready;
    assign led   = r_led;
    assign done  = r_done;

endmodule

// File: tb/tb_led_blink_encoder.sv
module tb_led_blink_encoder;

    localparam int W     = 4;
    localparam int SHORT = 2;
    localparam int LONG  = 6;
    localparam int GAP   = 3;
    localparam int FGAP  = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] data;
    logic         valid;
    logic         ready;
    logic         led;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;
    bit exp_q[$];

    led_blink_encoder #(
        .WIDTH(W), .SHORT_CYCLES(SHORT), .LONG_CYCLES(LONG),
        .GAP_CYCLES(GAP), .FRAME_GAP_CYCLES(FGAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .valid(valid),
        .ready(ready), .led(led), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference waveform: per bit MSB first, a lit run of LONG or SHORT cycles,
    // followed by a dark run of GAP (inter-bit) or FGAP (after last bit).
    function automatic void build(input logic [W-1:0] d);
        exp_q.delete();
        for (int b = W - 1; b >= 0; b--) begin
            for (int k = 0; k < (d[b] ? LONG : SHORT); k++) exp_q.push_back(1'b1);
            for (int k = 0; k < ((b == 0) ? FGAP : GAP); k++) exp_q.push_back(1'b0);
        end
    endfunction

    task automatic idle_chk(input string tag);
        chk({tag, "_led"},   32'(led),   32'd0);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_busy"},  32'(busy),  32'd0);
        chk({tag, "_done"},  32'(done),  32'd0);
    endtask

    // Entered #1 after the handshake edge; returns #1 after the edge into the done cycle.
    task automatic check_frame(input string tag, input logic [W-1:0] d, input bit scramble);
        build(d);
        for (int i = 0; i < exp_q.size(); i++) begin
            chk({tag, "_led"},  32'(led),   32'(exp_q[i]));
            chk({tag, "_busy"}, 32'(busy),  32'd1);
            chk({tag, "_rdy"},  32'(ready), 32'd0);
            chk({tag, "_done"}, 32'(done),  32'd0);
            if (scramble) begin
                valid = 1'($urandom_range(0, 1));
                data  = W'($urandom);
            end
            tick();
        end
        if (scramble) valid = 1'b0;
        chk({tag, "_done_pulse"}, 32'(done),  32'd1);
        chk({tag, "_done_rdy"},   32'(ready), 32'd1);
        chk({tag, "_done_led"},   32'(led),   32'd0);
        chk({tag, "_done_busy"},  32'(busy),  32'd0);
    endtask

    initial begin
        logic [W-1:0] d;
        int           gap;

        rst_n = 1'b0;
        valid = 1'b0;
        data  = '0;

        // Reset held for three edges, then released.
        for (int i = 0; i < 3; i++) begin
            tick();
            idle_chk("reset");
        end
        rst_n = 1'b1;
        tick();
        idle_chk("post_reset");

        // 1010 frame; data changes after the handshake must be ignored.
        data  = 4'b1010;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        data  = 4'b0101;
        check_frame("f1010", 4'b1010, 1'b0);
        tick();
        idle_chk("after_1010");

        // 0000 frame: four short flashes.
        data  = 4'b0000;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        check_frame("f0000", 4'b0000, 1'b0);
        tick();
        idle_chk("after_0000");

        // 0001 frame with 1111 offered throughout; accepted only in the done cycle.
        data  = 4'b0001;
        valid = 1'b1;
        tick();
        data  = 4'b1111;
        check_frame("f0001", 4'b0001, 1'b0);
        tick();
        valid = 1'b0;
        check_frame("f1111_b2b", 4'b1111, 1'b0);
        tick();
        idle_chk("after_b2b");

        // Reset in the middle of a 1010 frame.
        data  = 4'b1010;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        build(4'b1010);
        for (int i = 0; i < 12; i++) begin
            chk("abort_pre_led", 32'(led), 32'(exp_q[i]));
            if (i < 11) tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle_chk("abort_reset");
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_led",     32'(led),  32'd0);
        end
        data  = 4'b0100;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        check_frame("f0100", 4'b0100, 1'b0);
        tick();

        // Reset together with a handshake: the frame is not accepted.
        rst_n = 1'b0;
        data  = 4'b1111;
        valid = 1'b1;
        tick();
        rst_n = 1'b1;
        valid = 1'b0;
        idle_chk("rst_hs");
        for (int i = 0; i < 5; i++) begin
            tick();
            idle_chk("rst_hs_after");
        end

        // Random frames, random idle gaps (zero means back-to-back) and
        // random valid/data noise while busy.
        for (int f = 0; f < 20; f++) begin
            d     = W'($urandom);
            gap   = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                tick();
                idle_chk("rnd_idle");
            end
            data  = d;
            valid = 1'b1;
            tick();
            valid = 1'b0;
            check_frame("rnd", d, 1'b1);
        end
        tick();
        idle_chk("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_blink_encoder.md
LED_BLINK_ENCODER -- requirements
Module: led_blink_encoder

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 4: number of data bits per frame (>=1).
REQ-002 The block SHALL have the parameter SHORT_CYCLES, default 2: LED-on length for a 0 bit (>=1).
REQ-003 The block SHALL have the parameter LONG_CYCLES, default 6: LED-on length for a 1 bit (>SHORT_CYCLES).
REQ-004 The block SHALL have the parameter GAP_CYCLES, default 3: LED-off length between bits (>=1).
REQ-005 The block SHALL have the parameter FRAME_GAP_CYCLES, default 10: LED-off length after the last bit (>=1).
REQ-006 The block SHALL have the port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 The block SHALL have the port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-008 The block SHALL have the port data, input, WIDTH bits: value to display, sampled only at handshake.
REQ-009 The block SHALL have the port valid, input, 1 bit: data offered.
REQ-010 The block SHALL have the port ready, output, 1 bit: the block can accept a frame.
REQ-011 The block SHALL have the port led, output, 1 bit: registered LED drive, 1 = lit.
REQ-012 The block SHALL have the port busy, output, 1 bit: a frame is in progress.
REQ-013 The block SHALL have the port done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-014 FSM states SHALL be IDLE, ON, GAP and FGAP; ready = (state==IDLE); busy = ~ready.
REQ-015 A handshake SHALL occur on a rising edge with valid=1 and ready=1; data is then copied into a shift register, the bit index is set to WIDTH-1, and the state becomes ON.
REQ-016 Bits SHALL be sent MSB first; ON SHALL last exactly LONG_CYCLES cycles for a 1 bit and SHORT_CYCLES cycles for a 0 bit, with led=1.
REQ-017 After ON of a non-last bit: GAP for exactly GAP_CYCLES, led=0, then ON for the next bit.
REQ-018 After ON of the last bit: FGAP for exactly FRAME_GAP_CYCLES, led=0, with no inter-bit GAP, then IDLE.
REQ-019 Latency: for a handshake at edge of cycle t, led SHALL be 1 from cycle t+1.
REQ-020 done SHALL be 1 only in the first IDLE cycle after FGAP; ready is 1 in that same cycle.
REQ-021 A new handshake in the done cycle SHALL be accepted, giving back-to-back frames with no extra idle.
REQ-022 valid while busy SHALL be ignored, with no queuing; data changes after handshake SHALL have no effect.
REQ-023 In IDLE, led SHALL be 0.
REQ-024 The cycle counter SHALL be sized to hold the largest of the four length parameters and SHALL never wrap within a phase.

Reset
REQ-025 When rst_n=0 at a rising edge: state=IDLE, led=0, done=0, ready=1, busy=0, counter and shift register cleared.
REQ-026 Reset mid-frame SHALL abort the frame at the next edge with no done pulse; the first post-reset handshake starts a clean frame.
REQ-027 rst_n=0 SHALL override a simultaneous handshake, and the frame SHALL not be accepted.

Verification
Bench defaults: WIDTH=4, SHORT=2, LONG=6, GAP=3, FRAME_GAP=10.
REQ-028 The bench SHALL hold rst_n=0 for 3 cycles, then release -> led=0, ready=1, busy=0, done=0 throughout reset and in the first cycle after it.
REQ-029 The bench SHALL perform a handshake with data=4'b1010 at cycle t -> led=1 for t+1..t+6, 0 for t+7..t+9, 1 for t+10..t+11, 0 for t+12..t+14, 1 for t+15..t+20, 0 for t+21..t+23, 1 for t+24..t+25, 0 for t+26..t+35; done=1 and ready=1 only at t+36.
REQ-030 The bench SHALL perform a handshake with data=4'b0000 at t -> four 2-cycle pulses separated by 3-cycle gaps, FGAP of 10; done at t+28.
REQ-031 The bench SHALL hold valid=1 with data=4'b1111 during a 4'b0001 frame -> pattern unchanged (2,2,2,6 on-lengths); 4'b1111 is accepted only in the done cycle and then transmitted back-to-back (led=1 at done+1).
REQ-032 The bench SHALL drive rst_n=0 for 1 cycle at t+12 of a 4'b1010 frame -> led=0 and state=IDLE from the next edge, no done pulse; a new 4'b0100 handshake afterwards yields on-lengths 2,6,2,2.
REQ-033 The bench SHALL assert rst_n=0 and a handshake on the same edge -> no frame starts; led stays 0, ready=1 after reset.
